core_decode_stage: RTL and testbench
====================================

CORE_DECODE_STAGE -- requirements
Module: core_decode_stage

Interface
REQ-001 clk  input  1  core clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  fetch presents an instruction.
REQ-004 in_instr  input  32  raw RV64I instruction word.
REQ-005 in_pc  input  64  PC of in_instr.
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 flush  input  1  discard held and incoming instruction.
REQ-008 wb_en, wb_rd, wb_data  input  1/5/64  register-file write port.
REQ-009 out_valid  output  1  decoded bundle valid toward execute.
REQ-010 out_ready  input  1  execute consumes the bundle.
REQ-011 reg_read_data1, reg_read_data2, imm, pc  output  64 each  operands for execute.
REQ-012 funct3 (3), funct7 (7), opcode (7), format (3), rd (5), illegal (1)  outputs  decoded fields.

Function
REQ-013 The stage SHALL have one output register stage; a bundle accepted in cycle N appears on the outputs in cycle N+1.
REQ-014 in_ready SHALL equal (!out_valid || out_ready) && !flush; transfer in when in_valid && in_ready.
REQ-015 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-016 On out_valid && out_ready with no new transfer in, out_valid SHALL go 0 next cycle.
REQ-017 flush SHALL clear out_valid next cycle and block acceptance that cycle; flush wins over all simultaneous events.
REQ-018 format encoding: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-019 Opcode map: 0110011, 0111011 -> R; 0010011, 0011011, 0000011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; any other opcode -> format 7 and illegal=1.
REQ-020 imm SHALL be sign-extended to 64 bits per RISC-V I/S/B/U/J encodings; for R-type and illegal, imm=0.
REQ-021 funct7 SHALL be in_instr[31:25], except opcode 0010011 with funct3 001/101, which SHALL output {in_instr[31:26],1'b0}, so 64-bit shamt bit 5 is not read as funct7.
REQ-022 The register file SHALL hold 32x64-bit registers; x0 reads 0 and ignores writes.
REQ-023 Reads SHALL sample at acceptance; a same-cycle wb_en write to a read rs1/rs2 (nonzero) SHALL bypass wb_data into the captured operand.
REQ-024 Writeback SHALL proceed regardless of stall or flush.
REQ-025 For U/J formats, reg_read_data1/2 SHALL be 0; for I-type, reg_read_data2 SHALL be 0.

Reset
REQ-026 On rst_n low: out_valid=0, all data outputs 0, all 32 registers 0, illegal=0; in_ready SHALL be 1 one cycle after deassertion.
REQ-027 Reset asserted mid-stall SHALL drop the held bundle without handshake.

Structure
REQ-028 Format codes, opcode constants and a decoded-bundle struct SHALL live in shared package core_pkg.
REQ-029 The register file SHALL be sub-module core_regfile (2 read, 1 write, internal bypass); decode and immediate generation stay combinational in core_decode_stage.

Verification
REQ-030 After wb x5=0x10, issue addi x6,x5,-1 (0xFFF28313) -> next cycle format=1, imm=0xFFFF_FFFF_FFFF_FFFF, reg_read_data1=0x10, funct3=0.
REQ-031 srli x1,x2,33 (0x02115093) -> funct7=0000000, imm[5:0]=33; srai x1,x2,33 (0x42115093) -> funct7=0100000.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; on release, the next instruction appears one cycle later with no loss or duplication.
REQ-033 Write x7=0xDEAD in the same cycle an add x8,x7,x0 is accepted -> reg_read_data1=0xDEAD; write x0=5 -> later read of x0 returns 0.
REQ-034 Assert flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, the incoming instruction is dropped.
REQ-035 Opcode 0000000 -> illegal=1, format=7; beq (0x00208463) -> format=3, imm=8.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode definitions: instruction format codes, RV64I opcode constants,
// the registered decode bundle and the immediate generator.
package core_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        fmt_e            fmt;
        logic [4:0]      rd;
        logic            illegal;
    } decode_bundle_t;

    function automatic fmt_e opcode_format(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_OP, OP_OP32:                                  f = FMT_R;
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM:   f = FMT_I;
            OP_STORE:                                        f = FMT_S;
            OP_BRANCH:                                       f = FMT_B;
            OP_LUI, OP_AUIPC:                                f = FMT_U;
            OP_JAL:                                          f = FMT_J;
            default:                                         f = FMT_ILL;
        endcase
        return f;
    endfunction

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_regfile.sv
// 32x64 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle write data forwarded onto matching reads.
module core_regfile
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wen && waddr != '0) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass applies before the x0 override so a write to x0 never leaks through.
    always_comb begin
        rdata1 = regs_q[raddr1];
        if (wen && waddr == raddr1) begin
            rdata1 = wdata;
        end
        if (raddr1 == '0) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = regs_q[raddr2];
        if (wen && waddr == raddr2) begin
            rdata2 = wdata;
        end
        if (raddr2 == '0) begin
            rdata2 = '0;
        end
    end

endmodule

// File: rtl/core_decode_stage.sv
// RV64I decode stage: combinational field/immediate decode and operand read,
// captured into a single valid/ready output register toward execute.
module core_decode_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [63:0]     in_pc,
    output logic            in_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [63:0]     wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     reg_read_data1,
    output logic [63:0]     reg_read_data2,
    output logic [63:0]     imm,
    output logic [63:0]     pc,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [6:0]      opcode,
    output logic [2:0]      format,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [4:0]      rs1_c;
    logic [4:0]      rs2_c;
    logic [63:0]     rs1_val;
    logic [63:0]     rs2_val;
    logic [6:0]      opcode_c;
    fmt_e            fmt_c;
    decode_bundle_t  bundle_c;
    decode_bundle_t  bundle_q, bundle_d;
    logic            out_valid_q, out_valid_d;
    logic            accept;

    assign rs1_c    = in_instr[19:15];
    assign rs2_c    = in_instr[24:20];
    assign opcode_c = in_instr[6:0];
    assign fmt_c    = opcode_format(opcode_c);

    core_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1_c),
        .rdata1 (rs1_val),
        .raddr2 (rs2_c),
        .rdata2 (rs2_val),
        .wen    (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    always_comb begin
        bundle_c         = '0;
        bundle_c.opcode  = opcode_c;
        bundle_c.funct3  = in_instr[14:12];
        bundle_c.funct7  = in_instr[31:25];
        // slli/srli/srai: bit 25 is shamt[5], not part of funct7
        if (opcode_c == OP_IMM && in_instr[13:12] == 2'b01) begin
            bundle_c.funct7[0] = 1'b0;
        end
        bundle_c.rd      = in_instr[11:7];
        bundle_c.fmt     = fmt_c;
        bundle_c.illegal = (fmt_c == FMT_ILL);
        bundle_c.imm     = gen_imm(in_instr, fmt_c);
        bundle_c.pc      = in_pc;
        case (fmt_c)
            FMT_R, FMT_S, FMT_B: begin
                bundle_c.rs1_data = rs1_val;
                bundle_c.rs2_data = rs2_val;
            end
            FMT_I: begin
                bundle_c.rs1_data = rs1_val;
            end
            default: ;
        endcase
    end

    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = bundle_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign reg_read_data1 = bundle_q.rs1_data;
    assign reg_read_data2 = bundle_q.rs2_data;
    assign imm            = bundle_q.imm;
    assign pc             = bundle_q.pc;
    assign funct3         = bundle_q.funct3;
    assign funct7         = bundle_q.funct7;
    assign opcode         = bundle_q.opcode;
    assign format         = bundle_q.fmt;
    assign rd             = bundle_q.rd;
    assign illegal        = bundle_q.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: decode vector table, directed handshake/bypass/
// flush/reset sequences, then randomized traffic against a behavioural model.
module tb_core_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] reg_read_data1;
    logic [63:0] reg_read_data2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
    logic [2:0]  format;
    logic [4:0]  rd;
    logic        illegal;

    core_decode_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_ready       (in_ready),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .reg_read_data1 (reg_read_data1),
        .reg_read_data2 (reg_read_data2),
        .imm            (imm),
        .pc             (pc),
        .funct3         (funct3),
        .funct7         (funct7),
        .opcode         (opcode),
        .format         (format),
        .rd             (rd),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit        valid;
        bit [6:0]  op;
        bit [6:0]  f7;
        bit [2:0]  f3;
        bit [2:0]  fmt;
        bit [4:0]  rd;
        bit        ill;
        bit [63:0] imm;
        bit [63:0] d1;
        bit [63:0] d2;
        bit [63:0] pc;
    } exp_t;

    typedef struct {
        bit [31:0] instr;
        bit [2:0]  fmt;
        bit [63:0] imm;
        bit        ill;
    } vec_t;

    bit [63:0] mregs [32];
    bit        m_valid;
    exp_t      m_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode from the ISA rules: immediates by arithmetic shift of the
    // assembled field, operands chosen by which source registers a format uses.
    function automatic exp_t ref_decode(input bit [31:0] w, input bit [63:0] p,
                                        input bit [63:0] r1, input bit [63:0] r2);
        exp_t   e;
        longint s;
        e.valid = 1'b1;
        e.op    = w[6:0];
        e.f3    = w[14:12];
        e.f7    = w[31:25];
        e.rd    = w[11:7];
        e.pc    = p;
        e.ill   = 1'b0;
        case (w[6:0])
            7'h33, 7'h3B:                      e.fmt = 3'd0;
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h23:                             e.fmt = 3'd2;
            7'h63:                             e.fmt = 3'd3;
            7'h37, 7'h17:                      e.fmt = 3'd4;
            7'h6F:                             e.fmt = 3'd5;
            default: begin e.fmt = 3'd7; e.ill = 1'b1; end
        endcase
        case (e.fmt)
            3'd1:    s = longint'({w[31:20], 52'h0}) >>> 52;
            3'd2:    s = longint'({w[31:25], w[11:7], 52'h0}) >>> 52;
            3'd3:    s = longint'({w[31], w[7], w[30:25], w[11:8], 52'h0}) >>> 51;
            3'd4:    s = longint'({w[31:12], 44'h0}) >>> 32;
            3'd5:    s = longint'({w[31], w[19:12], w[20], w[30:21], 44'h0}) >>> 43;
            default: s = 0;
        endcase
        e.imm = s;
        if (w[6:0] == 7'h13 && w[13:12] == 2'b01) e.f7[0] = 1'b0;
        e.d1 = 64'd0;
        e.d2 = 64'd0;
        if (e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) begin
            e.d1 = r1;
            e.d2 = r2;
        end else if (e.fmt == 3'd1) begin
            e.d1 = r1;
        end
        return e;
    endfunction

    function automatic bit [63:0] mread(input bit [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".out_valid"}, out_valid, e.valid);
        if (e.valid) begin
            chk({tag, ".opcode"}, opcode, e.op);
            chk({tag, ".funct3"}, funct3, e.f3);
            chk({tag, ".funct7"}, funct7, e.f7);
            chk({tag, ".format"}, format, e.fmt);
            chk({tag, ".rd"}, rd, e.rd);
            chk({tag, ".illegal"}, illegal, e.ill);
            chk({tag, ".imm"}, imm, e.imm);
            chk({tag, ".rs1_data"}, reg_read_data1, e.d1);
            chk({tag, ".rs2_data"}, reg_read_data2, e.d2);
            chk({tag, ".pc"}, pc, e.pc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [31:0] w, input bit [63:0] p);
        in_valid  = 1'b1;
        in_instr  = w;
        in_pc     = p;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    vec_t vecs[$];
    bit [6:0] ops [13] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;

        // reset state
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.illegal", illegal, 0);
        chk("rst.imm", imm, 0);
        chk("rst.rs1_data", reg_read_data1, 0);
        chk("rst.rs2_data", reg_read_data2, 0);
        chk("rst.pc", pc, 0);
        chk("rst.fields", {funct3, funct7, opcode, format, rd}, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("rst.in_ready", in_ready, 1);

        // decode table
        vecs.push_back('{32'hFFF28313, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{32'h02115093, 3'd1, 64'h21, 1'b0});
        vecs.push_back('{32'h42115093, 3'd1, 64'h421, 1'b0});
        vecs.push_back('{32'h00000000, 3'd7, 64'h0, 1'b1});
        vecs.push_back('{32'h00208463, 3'd3, 64'h8, 1'b0});
        vecs.push_back('{32'hFE20AE23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        vecs.push_back('{32'h001000EF, 3'd5, 64'h800, 1'b0});
        vecs.push_back('{32'h800000EF, 3'd5, 64'hFFFF_FFFF_FFF0_0000, 1'b0});
        vecs.push_back('{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0});
        vecs.push_back('{32'h00001017, 3'd4, 64'h1000, 1'b0});
        vecs.push_back('{32'h123450B7, 3'd4, 64'h1234_5000, 1'b0});
        vecs.push_back('{32'h80013083, 3'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0});
        vecs.push_back('{32'h00000033, 3'd0, 64'h0, 1'b0});
        vecs.push_back('{32'h0000003B, 3'd0, 64'h0, 1'b0});
        vecs.push_back('{32'h80001063, 3'd3, 64'hFFFF_FFFF_FFFF_F000, 1'b0});
        vecs.push_back('{32'h0000007F, 3'd7, 64'h0, 1'b1});
        vecs.push_back('{32'h0000000F, 3'd7, 64'h0, 1'b1});
        vecs.push_back('{32'hFFC08067, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        vecs.push_back('{32'h00000073, 3'd1, 64'h0, 1'b0});
        foreach (vecs[i]) begin
            issue(vecs[i].instr, 64'h1000 + 64'(i) * 4);
            chk($sformatf("vec%0d.out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d.format", i), format, vecs[i].fmt);
            chk($sformatf("vec%0d.imm", i), imm, vecs[i].imm);
            chk($sformatf("vec%0d.illegal", i), illegal, vecs[i].ill);
            chk($sformatf("vec%0d.pc", i), pc, 64'h1000 + 64'(i) * 4);
        end

        // addi x6,x5,-1 after x5 = 0x10
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h10;
        tick();
        wb_en = 1'b0;
        issue(32'hFFF28313, 64'h2000);
        chk("addi.format", format, 1);
        chk("addi.imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.rs1_data", reg_read_data1, 64'h10);
        chk("addi.rs2_data", reg_read_data2, 0);
        chk("addi.funct3", funct3, 0);
        chk("addi.rd", rd, 6);

        // 64-bit shift amounts
        issue(32'h02115093, 64'h2004);
        chk("srli.funct7", funct7, 7'b0000000);
        chk("srli.shamt", imm[5:0], 33);
        issue(32'h42115093, 64'h2008);
        chk("srai.funct7", funct7, 7'b0100000);
        chk("srai.shamt", imm[5:0], 33);

        // same-cycle writeback bypass and x0
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD;
        issue(32'h00038433, 64'h2010);
        wb_en = 1'b0;
        chk("bypass.rs1_data", reg_read_data1, 64'hDEAD);
        chk("bypass.rs2_data", reg_read_data2, 0);
        chk("bypass.rd", rd, 8);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h5;
        issue(32'h000004B3, 64'h2014);
        wb_en = 1'b0;
        chk("x0_bypass.rs1_data", reg_read_data1, 0);
        issue(32'h000004B3, 64'h2018);
        chk("x0_read.rs1_data", reg_read_data1, 0);
        issue(32'h00738533, 64'h201C);
        chk("x7_kept.rs1_data", reg_read_data1, 64'hDEAD);
        chk("x7_kept.rs2_data", reg_read_data2, 64'hDEAD);

        // drain, then back-pressure for three cycles
        out_ready = 1'b1;
        tick();
        chk("drain.out_valid", out_valid, 0);
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h3000; out_ready = 1'b0;
        #1 chk("stall.accept_a.in_ready", in_ready, 1);
        tick();
        chk("stall.a.out_valid", out_valid, 1);
        in_instr = 32'h00200113; in_pc = 64'h3004;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("stall%0d.in_ready", k), in_ready, 0);
            tick();
            chk($sformatf("stall%0d.out_valid", k), out_valid, 1);
            chk($sformatf("stall%0d.pc", k), pc, 64'h3000);
            chk($sformatf("stall%0d.imm", k), imm, 64'h1);
            chk($sformatf("stall%0d.rd", k), rd, 1);
        end
        out_ready = 1'b1;
        #1 chk("release.in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("release.b.out_valid", out_valid, 1);
        chk("release.b.pc", pc, 64'h3004);
        chk("release.b.imm", imm, 64'h2);
        tick();
        chk("release.no_dup", out_valid, 0);

        // flush against a held bundle and an incoming one, writeback still lands
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h4000; out_ready = 1'b0;
        tick();
        chk("flush.pre.out_valid", out_valid, 1);
        in_instr = 32'h00300193; in_pc = 64'h4004; out_ready = 1'b1; flush = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd11; wb_data = 64'h77;
        #1 chk("flush.in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        chk("flush.out_valid", out_valid, 0);
        tick();
        chk("flush.dropped", out_valid, 0);
        issue(32'h00058633, 64'h4008);
        chk("flush.wb.rs1_data", reg_read_data1, 64'h77);

        // reset while stalled
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h5000; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rst_stall.pre.out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall.out_valid", out_valid, 0);
        chk("rst_stall.pc", pc, 0);
        chk("rst_stall.imm", imm, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_stall.in_ready", in_ready, 1);
        chk("rst_stall.still_empty", out_valid, 0);
        issue(32'hFFF28313, 64'h5004);
        chk("rst_stall.regs_cleared", reg_read_data1, 0);
        tick();

        // randomized traffic against the model
        foreach (mregs[i]) mregs[i] = 64'd0;
        m_valid = 1'b0;
        m_out   = '{default: 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit [31:0] w;
            bit        exp_ready;
            m_out.valid = m_valid;
            check_out($sformatf("rnd%0d", cyc), m_out);

            w = $urandom();
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
            in_instr  = w;
            in_pc     = {$urandom(), $urandom()};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = ($urandom_range(0, 3) == 0) ? w[19:15] : 5'($urandom_range(0, 31));
            wb_data   = {$urandom(), $urandom()};
            #1;
            exp_ready = (!m_valid || out_ready) && !flush;
            chk($sformatf("rnd%0d.in_ready", cyc), in_ready, exp_ready);

            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_out   = ref_decode(w, in_pc, mread(w[19:15]), mread(w[24:20]));
            end else if (out_ready) m_valid = 1'b0;
            if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
